amber: RTL and testbench
========================

// Module: amber
// PURPOSE
//  Minimal multicycle capability (CHERI-style) core. It fetches 24-bit words from a
//  private instruction memory and executes capability loads into a capability register
//  file from a private data memory. It sits at chip top; its only ports are clock and reset.
//  Internal instances (hierarchical names are fixed, benches poke them directly):
//    u_imem.r_mem[], u_dmem.r_mem[] (24-bit words);
//    u_regcr.r_base/r_len/r_cur[] (48-bit), r_perms/r_attr[] (24-bit), r_tag[] (1-bit).
// PARAMETERS
//  IMEM_DEPTH  4096  instruction words in u_imem
//  DMEM_DEPTH  4096  data words in u_dmem
//  NCR         4     capability registers in u_regcr (index field is 2 bits)
// PORTS
//  iw_clk  in  1  single clock, all state updates on posedge
//  iw_rst  in  1  reset, synchronous, active-low
// BEHAVIOUR
//  - Reset (iw_rst low at posedge): pc=0, state=FETCH, halted=0, fault=0. CR regs and
//    memories are NOT cleared, so contents preloaded before/after reset survive.
//  - Instruction word: [23:16] opcode (OPC_* from src/opcodes.vh), [15:14] CRt,
//    [13:12] CRs, [11:2] imm10 (signed). Fields are CLDcso-specific; HLT ignores [15:0].
//  - FSM: FETCH -> DECODE -> (LOAD x12 -> WB -> FETCH) | HALT | FAULT.
//    HALT and FAULT are terminal until reset. Unknown opcode is a NOP: pc+1, back to FETCH.
//  - u_imem and u_dmem have synchronous read with 1-cycle latency. One dmem read per cycle.
//  - CLDcso CRt, imm(CRs):
//    ea = r_cur[CRs] + sext(imm10), computed modulo 2^48.
//    Checks, all required: r_tag[CRs]==1; r_perms[CRs][CR_PERM_LC_BIT]==1 (src/cr.vh).
//    Any failed check -> FAULT; CRt is left unchanged.
//    On pass, read 12 consecutive words at ea..ea+11 (dmem address = ea low bits):
//      +0/+1 base lo/hi, +2/+3 len lo/hi, +4/+5 cur lo/hi, +6 perms (+7 ignored),
//      +8 attr (+9 ignored), +10 bit0 = tag (+11 ignored).
//    Assemble the fields into shadow registers.
//    WB commits all six fields to CRt in one cycle (atomic: no partial update).
//    CRt==CRs is legal; the old value is used for ea and the new value is written.
//    Then pc+1.
//  - HLT: enter HALT. pc stays at the HLT address and no further memory access occurs.
//  - Latency: CLDcso completes in <= 16 cycles. The program below finishes well inside
//    200 clocks.
//  - Reset mid-operation (for example during LOAD) aborts the instruction.
//    A pending WB is discarded; CR contents are unchanged.
// CONFIGURATION
//  AMBER_CAP_BOUNDS_CHECK_EN:
//    defined   -> CLDcso additionally requires ea >= r_base[CRs] and
//                 ea+12 <= r_base[CRs]+r_len[CRs] (49-bit compare, no wrap).
//                 Violation -> FAULT, CRt unchanged.
//    undefined -> no bounds check. Only tag and LC permission are enforced.
// TESTING
//  1. CR0{base=0, len=1000, cur=500, perms=LC, tag=1}; dmem[500..511]=42,7,88,9,123,3,EE,0,AA,0,1,0;
//     imem: CLDcso #0(CR0),CR1 ; HLT -> within 200 clk CR1 base=0x000007_00002A,
//     len=0x000009_000058, cur=0x000003_00007B, perms=0x0000EE, attr=0x0000AA, tag=1.
//  2. Same as 1 with r_perms[0]=0 -> FAULT state; CR1 keeps its prior value
//     (for example tag=0, base=0).
//  3. Same as 1 with r_tag[0]=0 -> FAULT; CR1 unchanged.
//  4. Same as 1 with cur=512, imm=-12 (0x3F4) -> loads from 500; same CR1 values as test 1.
//  5. AMBER_CAP_BOUNDS_CHECK_EN defined, cur=995 -> FAULT; without the macro -> loads 995..1006.
//  6. Assert iw_rst low during LOAD beat 5, then release -> CR1 unchanged; restarts at pc=0;
//     on HLT, pc is held and no dmem activity occurs.

Source files
------------

// File: rtl/amber.sv
// amber: multicycle capability core that executes CLDcso loads from a private data memory.
// Optional AMBER_CAP_BOUNDS_CHECK_EN adds an ea bounds check against the source capability.

module amber_mem #(
  parameter int DEPTH = 4096,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          re_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [23:0]   wdata_i,
  output logic [23:0]   rdata_o
);
  logic [23:0] r_mem [DEPTH];
  logic [23:0] rdata_q;

  // The write port is left for an external loader; the core only reads.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= r_mem[addr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

module amber_regcr #(
  parameter int NCR = 4
) (
  input  logic        clk_i,
  input  logic [1:0]  rs_i,
  output logic [47:0] rs_base_o,
  output logic [47:0] rs_len_o,
  output logic [47:0] rs_cur_o,
  output logic [23:0] rs_perms_o,
  output logic [23:0] rs_attr_o,
  output logic        rs_tag_o,
  input  logic        we_i,
  input  logic [1:0]  rt_i,
  input  logic [47:0] w_base_i,
  input  logic [47:0] w_len_i,
  input  logic [47:0] w_cur_i,
  input  logic [23:0] w_perms_i,
  input  logic [23:0] w_attr_i,
  input  logic        w_tag_i
);
  logic [47:0] r_base  [NCR];
  logic [47:0] r_len   [NCR];
  logic [47:0] r_cur   [NCR];
  logic [23:0] r_perms [NCR];
  logic [23:0] r_attr  [NCR];
  logic        r_tag   [NCR];

  // All six fields land in the same edge so a capability is never half-written.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_base[rt_i]  <= w_base_i;
      r_len[rt_i]   <= w_len_i;
      r_cur[rt_i]   <= w_cur_i;
      r_perms[rt_i] <= w_perms_i;
      r_attr[rt_i]  <= w_attr_i;
      r_tag[rt_i]   <= w_tag_i;
    end
  end

  assign rs_base_o  = r_base[rs_i];
  assign rs_len_o   = r_len[rs_i];
  assign rs_cur_o   = r_cur[rs_i];
  assign rs_perms_o = r_perms[rs_i];
  assign rs_attr_o  = r_attr[rs_i];
  assign rs_tag_o   = r_tag[rs_i];
endmodule

module amber #(
  parameter int IMEM_DEPTH = 4096,
  parameter int DMEM_DEPTH = 4096,
  parameter int NCR        = 4
) (
  input logic iw_clk,
  input logic iw_rst
);
  localparam int IAW = $clog2(IMEM_DEPTH);
  localparam int DAW = $clog2(DMEM_DEPTH);
  localparam logic [7:0] OPC_CLDCSO = 8'h20;
  localparam logic [7:0] OPC_HLT    = 8'hFF;
  localparam int CR_PERM_LC_BIT = 0;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_LOAD   = 3'd2,
    ST_WB     = 3'd3,
    ST_HALT   = 3'd4,
    ST_FAULT  = 3'd5
  } state_e;

  state_e         state_q;
  logic [IAW-1:0] pc_q;
  logic           halted_q;
  logic           fault_q;
  logic [3:0]     beat_q;
  logic [47:0]    ea_q;
  logic [1:0]     crt_q;
  logic [47:0]    sh_base_q, sh_len_q, sh_cur_q;
  logic [23:0]    sh_perms_q, sh_attr_q;
  logic           sh_tag_q;

  logic [23:0]    inst_s, dm_rdata_s;
  logic [7:0]     opc_s;
  logic [1:0]     crt_s, crs_s;
  logic [9:0]     imm_s;
  logic [47:0]    ea_d;
  logic [47:0]    rs_base_s, rs_len_s, rs_cur_s;
  logic [23:0]    rs_perms_s, rs_attr_s;
  logic           rs_tag_s;
  logic           cap_ok_s, bounds_ok_s;
  logic           im_re_s, dm_re_s, wb_we_s;
  logic [DAW-1:0] dm_addr_s;
  logic           unused_s;

  assign opc_s = inst_s[23:16];
  assign crt_s = inst_s[15:14];
  assign crs_s = inst_s[13:12];
  assign imm_s = inst_s[11:2];
  assign ea_d  = rs_cur_s + {{38{imm_s[9]}}, imm_s};

  assign im_re_s   = (state_q == ST_FETCH);
  assign dm_re_s   = (state_q == ST_LOAD) && (beat_q < 4'd12);
  assign dm_addr_s = ea_q[DAW-1:0] + DAW'(beat_q);
  // A reset sampled on the WB edge must discard the commit.
  assign wb_we_s   = (state_q == ST_WB) && iw_rst;
  assign unused_s  = ^{inst_s[1:0], ea_q[47:DAW], rs_attr_s, rs_base_s, rs_len_s};

  // Capability checks on the source register, evaluated in DECODE.
  always_comb begin
    cap_ok_s = rs_tag_s & rs_perms_s[CR_PERM_LC_BIT];
`ifdef AMBER_CAP_BOUNDS_CHECK_EN
    bounds_ok_s = (ea_d >= rs_base_s) &&
                  (({1'b0, ea_d} + 49'd12) <= ({1'b0, rs_base_s} + {1'b0, rs_len_s}));
`else
    bounds_ok_s = 1'b1;
`endif
  end

  amber_mem #(.DEPTH(IMEM_DEPTH)) u_imem (
    .clk_i(iw_clk), .re_i(im_re_s), .we_i(1'b0), .addr_i(pc_q),
    .wdata_i(24'h000000), .rdata_o(inst_s)
  );

  amber_mem #(.DEPTH(DMEM_DEPTH)) u_dmem (
    .clk_i(iw_clk), .re_i(dm_re_s), .we_i(1'b0), .addr_i(dm_addr_s),
    .wdata_i(24'h000000), .rdata_o(dm_rdata_s)
  );

  amber_regcr #(.NCR(NCR)) u_regcr (
    .clk_i(iw_clk), .rs_i(crs_s),
    .rs_base_o(rs_base_s), .rs_len_o(rs_len_s), .rs_cur_o(rs_cur_s),
    .rs_perms_o(rs_perms_s), .rs_attr_o(rs_attr_s), .rs_tag_o(rs_tag_s),
    .we_i(wb_we_s), .rt_i(crt_q),
    .w_base_i(sh_base_q), .w_len_i(sh_len_q), .w_cur_i(sh_cur_q),
    .w_perms_i(sh_perms_q), .w_attr_i(sh_attr_q), .w_tag_i(sh_tag_q)
  );

  // Control FSM; LOAD issues reads for beats 0..11 and captures each one a cycle later.
  always_ff @(posedge iw_clk) begin
    if (!iw_rst) begin
      state_q    <= ST_FETCH;
      pc_q       <= '0;
      halted_q   <= 1'b0;
      fault_q    <= 1'b0;
      beat_q     <= 4'd0;
      ea_q       <= 48'd0;
      crt_q      <= 2'd0;
      sh_base_q  <= 48'd0;
      sh_len_q   <= 48'd0;
      sh_cur_q   <= 48'd0;
      sh_perms_q <= 24'd0;
      sh_attr_q  <= 24'd0;
      sh_tag_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: state_q <= ST_DECODE;
        ST_DECODE: begin
          if (opc_s == OPC_CLDCSO) begin
            ea_q   <= ea_d;
            crt_q  <= crt_s;
            beat_q <= 4'd0;
            if (cap_ok_s && bounds_ok_s) begin
              state_q <= ST_LOAD;
            end else begin
              state_q <= ST_FAULT;
              fault_q <= 1'b1;
            end
          end else if (opc_s == OPC_HLT) begin
            state_q  <= ST_HALT;
            halted_q <= 1'b1;
          end else begin
            pc_q    <= pc_q + IAW'(1);
            state_q <= ST_FETCH;
          end
        end
        ST_LOAD: begin
          beat_q <= beat_q + 4'd1;
          case (beat_q)
            4'd1:    sh_base_q[23:0]  <= dm_rdata_s;
            4'd2:    sh_base_q[47:24] <= dm_rdata_s;
            4'd3:    sh_len_q[23:0]   <= dm_rdata_s;
            4'd4:    sh_len_q[47:24]  <= dm_rdata_s;
            4'd5:    sh_cur_q[23:0]   <= dm_rdata_s;
            4'd6:    sh_cur_q[47:24]  <= dm_rdata_s;
            4'd7:    sh_perms_q       <= dm_rdata_s;
            4'd9:    sh_attr_q        <= dm_rdata_s;
            4'd11:   sh_tag_q         <= dm_rdata_s[0];
            default: begin end
          endcase
          if (beat_q == 4'd12) begin
            state_q <= ST_WB;
          end
        end
        ST_WB: begin
          pc_q    <= pc_q + IAW'(1);
          state_q <= ST_FETCH;
        end
        ST_HALT:  state_q <= ST_HALT;
        ST_FAULT: state_q <= ST_FAULT;
        default: begin
          state_q <= ST_FAULT;
          fault_q <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_amber.sv
// Directed bench for amber: preloads memories and capability registers, runs short programs.
module tb_amber;
  localparam logic [7:0] OPC_CLD = 8'h20;
  localparam logic [7:0] OPC_HLT = 8'hFF;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   vec_cnt = 0;
  int   err_cnt = 0;

  amber dut (.iw_clk(clk), .iw_rst(rst_n));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] cld(input logic [1:0] crt, input logic [1:0] crs,
                                      input logic [9:0] imm);
    return {OPC_CLD, crt, crs, imm, 2'b00};
  endfunction

  task automatic set_cr(input logic [1:0] i, input logic [47:0] b, input logic [47:0] l,
                        input logic [47:0] c, input logic [23:0] p, input logic [23:0] a,
                        input logic t);
    dut.u_regcr.r_base[i]  = b;
    dut.u_regcr.r_len[i]   = l;
    dut.u_regcr.r_cur[i]   = c;
    dut.u_regcr.r_perms[i] = p;
    dut.u_regcr.r_attr[i]  = a;
    dut.u_regcr.r_tag[i]   = t;
  endtask

  // Hold reset, load a two-word program and set CR0 / clear CR1.
  task automatic prep(input logic [47:0] cur0, input logic [23:0] perms0, input logic tag0,
                      input logic [23:0] w0);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    dut.u_imem.r_mem[0] = w0;
    dut.u_imem.r_mem[1] = {OPC_HLT, 16'h0000};
    set_cr(2'd0, 48'd0, 48'd1000, cur0, perms0, 24'd0, tag0);
    set_cr(2'd1, 48'd0, 48'd0, 48'd0, 24'd0, 24'd0, 1'b0);
  endtask

  task automatic run(input string tag);
    bit done;
    done  = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (dut.halted_q || dut.fault_q) begin
        done = 1'b1;
        break;
      end
    end
    chk({tag, "_done"}, 64'(done), 64'd1);
  endtask

  task automatic chk_cr1(input string tag, input logic [47:0] b, input logic [47:0] l,
                         input logic [47:0] c, input logic [23:0] p, input logic [23:0] a,
                         input logic t);
    chk({tag, "_base"},  64'(dut.u_regcr.r_base[1]),  64'(b));
    chk({tag, "_len"},   64'(dut.u_regcr.r_len[1]),   64'(l));
    chk({tag, "_cur"},   64'(dut.u_regcr.r_cur[1]),   64'(c));
    chk({tag, "_perms"}, 64'(dut.u_regcr.r_perms[1]), 64'(p));
    chk({tag, "_attr"},  64'(dut.u_regcr.r_attr[1]),  64'(a));
    chk({tag, "_tag"},   64'(dut.u_regcr.r_tag[1]),   64'(t));
  endtask

  task automatic chk_cr1_t1(input string tag);
    chk_cr1(tag, 48'h000007_00002A, 48'h000009_000058, 48'h000003_00007B,
            24'h0000EE, 24'h0000AA, 1'b1);
  endtask

  task automatic chk_cr1_zero(input string tag);
    chk_cr1(tag, 48'd0, 48'd0, 48'd0, 24'd0, 24'd0, 1'b0);
  endtask

  initial begin
    logic [23:0] d500 [12];
    bit          found;
    int          act;
    d500 = '{24'd42, 24'd7, 24'd88, 24'd9, 24'd123, 24'd3,
             24'hEE, 24'd0, 24'hAA, 24'd0, 24'd1, 24'd0};
    for (int i = 0; i < 12; i++) dut.u_dmem.r_mem[500 + i] = d500[i];
    for (int i = 0; i < 12; i++) dut.u_dmem.r_mem[995 + i] = 24'h000100 + 24'(i);
    dut.u_dmem.r_mem[1005] = 24'hFFFFF3;
    for (int i = 0; i < 7; i++) dut.u_dmem.r_mem[988 + i] = 24'h000200 + 24'(i);

    // Reset state
    prep(48'd500, 24'h000001, 1'b1, cld(2'd1, 2'd0, 10'd0));
    chk("rst_pc", 64'(dut.pc_q), 64'd0);
    chk("rst_state", 64'(dut.state_q), 64'd0);
    chk("rst_halted", 64'(dut.halted_q), 64'd0);
    chk("rst_fault", 64'(dut.fault_q), 64'd0);

    // 1: basic load into CR1
    run("t1");
    chk("t1_halted", 64'(dut.halted_q), 64'd1);
    chk("t1_fault", 64'(dut.fault_q), 64'd0);
    chk("t1_pc", 64'(dut.pc_q), 64'd1);
    chk_cr1_t1("t1");

    // 2: missing LC permission
    prep(48'd500, 24'h000000, 1'b1, cld(2'd1, 2'd0, 10'd0));
    run("t2");
    chk("t2_fault", 64'(dut.fault_q), 64'd1);
    chk("t2_halted", 64'(dut.halted_q), 64'd0);
    chk("t2_pc", 64'(dut.pc_q), 64'd0);
    chk_cr1_zero("t2");

    // 3: untagged source
    prep(48'd500, 24'h000001, 1'b0, cld(2'd1, 2'd0, 10'd0));
    run("t3");
    chk("t3_fault", 64'(dut.fault_q), 64'd1);
    chk_cr1_zero("t3");

    // 4: negative immediate
    prep(48'd512, 24'h000001, 1'b1, cld(2'd1, 2'd0, 10'h3F4));
    run("t4");
    chk("t4_halted", 64'(dut.halted_q), 64'd1);
    chk_cr1_t1("t4");

    // CRt == CRs: old value forms ea, new value is written
    prep(48'd500, 24'h000001, 1'b1, cld(2'd0, 2'd0, 10'd0));
    run("same");
    chk("same_cur", 64'(dut.u_regcr.r_cur[0]), 64'h000003_00007B);
    chk("same_base", 64'(dut.u_regcr.r_base[0]), 64'h000007_00002A);
    chk("same_perms", 64'(dut.u_regcr.r_perms[0]), 64'h0000EE);

    // 5: ea near the end of the region
    prep(48'd995, 24'h000001, 1'b1, cld(2'd1, 2'd0, 10'd0));
    run("t5");
`ifdef AMBER_CAP_BOUNDS_CHECK_EN
    chk("t5_fault", 64'(dut.fault_q), 64'd1);
    chk_cr1_zero("t5");
`else
    chk("t5_fault", 64'(dut.fault_q), 64'd0);
    chk_cr1("t5", 48'h000101_000100, 48'h000103_000102, 48'h000105_000104,
            24'h000106, 24'h000108, 1'b1);
`endif

    // ea+12 exactly at base+len is in bounds either way
    prep(48'd988, 24'h000001, 1'b1, cld(2'd1, 2'd0, 10'd0));
    run("t5b");
    chk("t5b_fault", 64'(dut.fault_q), 64'd0);
    chk_cr1("t5b", 48'h000201_000200, 48'h000203_000202, 48'h000205_000204,
            24'h000206, 24'h000101, 1'b1);

    // Unknown opcode behaves as NOP
    prep(48'd500, 24'h000001, 1'b1, 24'h550000);
    run("nop");
    chk("nop_pc", 64'(dut.pc_q), 64'd1);
    chk("nop_halted", 64'(dut.halted_q), 64'd1);
    chk("nop_cr1_tag", 64'(dut.u_regcr.r_tag[1]), 64'd0);

    // 6: reset during LOAD beat 5, then rerun and hold in HALT
    prep(48'd500, 24'h000001, 1'b1, cld(2'd1, 2'd0, 10'd0));
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dut.state_q == 3'd2 && dut.beat_q == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    chk("t6_reach_beat5", 64'(found), 64'd1);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_rst_pc", 64'(dut.pc_q), 64'd0);
    chk("t6_rst_state", 64'(dut.state_q), 64'd0);
    chk_cr1_zero("t6_abort");
    run("t6");
    chk_cr1_t1("t6");
    act = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (dut.u_dmem.re_i || dut.u_imem.re_i) act++;
    end
    chk("t6_hold_pc", 64'(dut.pc_q), 64'd1);
    chk("t6_halt_mem_act", 64'(act), 64'd0);

    // Reset sampled on the WB edge discards the commit
    prep(48'd500, 24'h000001, 1'b1, cld(2'd1, 2'd0, 10'd0));
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (dut.state_q == 3'd3) begin
        found = 1'b1;
        break;
      end
    end
    chk("t7_reach_wb", 64'(found), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk_cr1_zero("t7");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
